imuldiv_div_arbiter: RTL
========================

IMULDIV_DIV_ARBITER -- requirements
Module: imuldiv_div_arbiter

Interface
REQ-001 Parameters: none; operand width SHALL be fixed at 32 bits, result width at 64 bits ({remainder[63:32], quotient[31:0]}).
REQ-002 clk  input  1  sole clock; all state SHALL update on posedge clk.
REQ-003 reset  input  1  synchronous, active-low reset (0 = reset).
REQ-004 req0_fn / req1_fn  input  1 each  1 = signed div/rem, 0 = divu/remu.
REQ-005 req0_a, req0_b / req1_a, req1_b  input  32 each  dividend, divisor.
REQ-006 req0_val / req1_val  input  1 each; req0_rdy / req1_rdy  output  1 each  request handshakes.
REQ-007 resp0_result / resp1_result  output  64 each  response payload.
REQ-008 resp0_val / resp1_val  output  1 each; resp0_rdy / resp1_rdy  input  1 each  response handshakes.
REQ-009 divreq_msg_fn 1, divreq_msg_a 32, divreq_msg_b 32, divreq_val 1  outputs; divreq_rdy  input  1  shared-divider request port.
REQ-010 divresp_msg_result  input  64; divresp_val  input  1; divresp_rdy  output  1  shared-divider response port.

Function
REQ-011 Transfer SHALL occur on any port only in a cycle where val && rdy are both high.
REQ-012 FSM states SHALL be IDLE, ISSUE, WAIT, RESP; at most one transaction outstanding.
REQ-013 IDLE: if any reqN_val, grant exactly one requester; assert only that reqN_rdy combinationally; latch fn/a/b and owner ID; next state ISSUE.
REQ-014 Grant SHALL be round-robin: a 1-bit priority pointer selects the preferred requester; if only one is valid, it wins regardless of pointer.
REQ-015 Pointer SHALL update to the non-owner on completion of the RESP handshake; pointer reset value = requester 0.
REQ-016 ISSUE: divreq_val = 1 with latched operands held stable; on divreq_rdy go to WAIT.
REQ-017 WAIT: divresp_rdy = 1; on divresp_val latch divresp_msg_result; go to RESP.
REQ-018 RESP: assert respN_val for owner only, respN_result = latched result; hold until respN_rdy; then go to IDLE.
REQ-019 Non-owner respN_val SHALL be 0; both reqN_rdy SHALL be 0 outside IDLE.
REQ-020 divreq_val SHALL be 0 outside ISSUE; divresp_rdy SHALL be 0 outside WAIT.
REQ-021 Minimum latency, request accept to respN_val: 3 cycles plus divider latency (accept t, divreq_val t+1, response latched >= t+2, respN_val next cycle).
REQ-022 Simultaneous req0_val and req1_val: pointer holder wins; loser's rdy stays 0 and its request stays pending unchanged.
REQ-023 Responses SHALL return in issue order and never be dropped or duplicated; respN_result SHALL be stable while respN_val && !respN_rdy.

Reset
REQ-024 While reset == 0 at a clock edge: state -> IDLE, pointer -> 0, all val/rdy outputs -> 0, latched operand/result registers -> 0.
REQ-025 Reset mid-transaction SHALL abandon it with no response; the divider SHALL be reset by the same event at integration.
REQ-026 Outputs SHALL reflect reset values from the first edge with reset low until the first edge after reset returns high.

Configuration
REQ-027 Macro IMULDIV_DIV_ZERO_BYPASS_EN.
REQ-028 Defined: on grant with b == 0, FSM SHALL skip ISSUE/WAIT and enter RESP directly with result {a, 32'hffffffff}; the divider is not accessed.
REQ-029 Undefined: divide-by-zero is forwarded to the divider like any other request; the divider's result is returned unchanged.

Verification
REQ-030 req0 only: fn=1, a=0x222, b=0x2a -> resp0_result=64'h00000000_0000000d; resp1_val never 1.
REQ-031 req1 only: fn=1, a=0x222, b=0x32 -> resp1_result=64'h0000002e_0000000a.
REQ-032 Both valid every cycle for 8 transactions (req0 fn=0 a=0xffffffff b=1; req1 fn=1 a=0xffffffff b=0xffffffff) -> strict alternation 0,1,0,1...; results 64'h00000000_ffffffff and 64'h00000000_00000001.
REQ-033 Random sink stall on resp0_rdy (3-cycle gaps) plus divreq_rdy low 5 cycles -> result held stable, no second grant until RESP completes.
REQ-034 reset driven low in WAIT -> no response emitted; next request afterwards is served by requester 0 priority with correct result.
REQ-035 With IMULDIV_DIV_ZERO_BYPASS_EN: a=0x12345678, b=0 -> 64'h12345678_ffffffff, divreq_val never asserted; without it, the request reaches the divider.

Source files
------------

// File: rtl/imuldiv_div_arbiter.sv
// Round-robin arbiter sharing one divider between two requesters, one transaction in flight.
// Optional macro IMULDIV_DIV_ZERO_BYPASS_EN answers divide-by-zero locally without using the divider.
module imuldiv_div_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_fn,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req0_val,
  output logic        req0_rdy,
  input  logic        req1_fn,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic        req1_val,
  output logic        req1_rdy,
  output logic [63:0] resp0_result,
  output logic        resp0_val,
  input  logic        resp0_rdy,
  output logic [63:0] resp1_result,
  output logic        resp1_val,
  input  logic        resp1_rdy,
  output logic        divreq_msg_fn,
  output logic [31:0] divreq_msg_a,
  output logic [31:0] divreq_msg_b,
  output logic        divreq_val,
  input  logic        divreq_rdy,
  input  logic [63:0] divresp_msg_result,
  input  logic        divresp_val,
  output logic        divresp_rdy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t      state, state_next;
  logic        ptr, owner, fn_q, active;
  logic [31:0] a_q, b_q;
  logic [63:0] result_q;
  logic        grant_any, grant_id, sel_fn, resp_fire;
  logic [31:0] sel_a, sel_b;

  // active holds request ready low until the first edge after reset is released
  always_comb begin
    grant_any = active && (state == IDLE) && (req0_val || req1_val);
    grant_id  = (req0_val && req1_val) ? ptr : req1_val;
    sel_fn    = grant_id ? req1_fn : req0_fn;
    sel_a     = grant_id ? req1_a  : req0_a;
    sel_b     = grant_id ? req1_b  : req0_b;
    resp_fire = (state == RESP) && (owner ? resp1_rdy : resp0_rdy);
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (grant_any) begin
`ifdef IMULDIV_DIV_ZERO_BYPASS_EN
        state_next = (sel_b == 32'd0) ? RESP : ISSUE;
`else
        state_next = ISSUE;
`endif
      end
      ISSUE: if (divreq_rdy)  state_next = WAIT;
      WAIT:  if (divresp_val) state_next = RESP;
      RESP:  if (resp_fire)   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req0_rdy      = grant_any && !grant_id;
    req1_rdy      = grant_any && grant_id;
    divreq_val    = (state == ISSUE);
    divresp_rdy   = (state == WAIT);
    resp0_val     = (state == RESP) && !owner;
    resp1_val     = (state == RESP) && owner;
    divreq_msg_fn = fn_q;
    divreq_msg_a  = a_q;
    divreq_msg_b  = b_q;
    resp0_result  = result_q;
    resp1_result  = result_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      active   <= 1'b0;
      ptr      <= 1'b0;
      owner    <= 1'b0;
      fn_q     <= 1'b0;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      result_q <= 64'd0;
    end else begin
      state  <= state_next;
      active <= 1'b1;
      if (grant_any) begin
        owner <= grant_id;
        fn_q  <= sel_fn;
        a_q   <= sel_a;
        b_q   <= sel_b;
`ifdef IMULDIV_DIV_ZERO_BYPASS_EN
        if (sel_b == 32'd0) result_q <= {sel_a, 32'hffffffff};
`endif
      end
      if (state == WAIT && divresp_val) result_q <= divresp_msg_result;
      // hand priority to the other requester once the response has been taken
      if (resp_fire) ptr <= ~owner;
    end
  end

endmodule
